// File: rtl/sprite_line_buffer.sv
// sprite_line_buffer: double-banked scan-line buffer that z-merges 8-pixel sprite slices and shifts the display line to the palette stage.
//   clk, rst            clock, synchronous active-high reset
//   line_load/addr/tile/z/palette, line_busy   slice handshake from the sprite engine
//   line_copy, line_shift                      bank swap (rising edge) and display advance
//   tile_addr, tile_data                       tile-row fetch (data valid one cycle after address)
//   pixel                                      {palette, index} of the current display pixel
module sprite_line_buffer #(
  parameter int WIDTH = 640,
  parameter int ADDR_BITS = 10,
  parameter int TILE_ADDR_BITS = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      line_load,
  input  logic [ADDR_BITS-1:0]      line_addr,
  input  logic [TILE_ADDR_BITS-1:0] line_tile,
  input  logic [1:0]                line_z,
  input  logic [3:0]                line_palette,
  output logic                      line_busy,
  input  logic                      line_copy,
  input  logic                      line_shift,
  output logic [TILE_ADDR_BITS-1:0] tile_addr,
  input  logic [31:0]               tile_data,
  output logic [7:0]                pixel
);
  localparam logic [ADDR_BITS:0] LIM = (ADDR_BITS+1)'(WIDTH);
  typedef enum logic [1:0] {IDLE, FETCH, LATCH, WRITE} state_t;
  state_t state, state_nx;
  logic bank_sel, copy_d, swap;
  logic [ADDR_BITS-1:0] addr, rd_ptr, m_idx, r_idx;
  logic [1:0] z;
  logic [3:0] pal;
  logic [2:0] k;
  logic [31:0] row;
  logic [9:0] bank0 [WIDTH];
  logic [9:0] bank1 [WIDTH];
  logic [9:0] front_rd, back_rd, entry;
  logic [ADDR_BITS:0] target;
  logic in_range, rd_ok, merge_we, disp_we;
  assign swap = line_copy & ~copy_d;
  assign line_busy = line_load | (state != IDLE);
  assign target = {1'b0, addr} + (ADDR_BITS+1)'(k);
  assign in_range = target < LIM;
  assign m_idx = in_range ? target[ADDR_BITS-1:0] : '0;
  assign front_rd = bank_sel ? bank1[m_idx] : bank0[m_idx];
  assign entry = {z, pal, row[3:0]};
  // {z,8'h00} > entry is true exactly when z beats the stored depth, so z ties keep the old entry
  assign merge_we = (state == WRITE) & in_range & (row[3:0] != 4'd0) &
                    ((front_rd[3:0] == 4'd0) | ({z, 8'h00} > front_rd)) & ~swap & ~rst;
  assign rd_ok = {1'b0, rd_ptr} < LIM;
  assign r_idx = rd_ok ? rd_ptr : '0;
  assign back_rd = bank_sel ? bank0[r_idx] : bank1[r_idx];
  assign disp_we = line_shift & rd_ok & ~swap & ~rst;
  always_comb begin
    state_nx = state;
    state_nx = swap ? IDLE :
               state == IDLE  ? (line_load ? FETCH : IDLE) :
               state == FETCH ? LATCH :
               state == LATCH ? WRITE :
               (k == 3'd7 ? IDLE : WRITE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bank_sel <= 1'b0;
      copy_d <= 1'b0;
      rd_ptr <= '0;
      pixel <= '0;
      tile_addr <= '0;
      addr <= '0;
      z <= '0;
      pal <= '0;
      k <= '0;
      row <= '0;
    end else begin
      state <= state_nx;
      copy_d <= line_copy;
      if (swap) begin
        bank_sel <= ~bank_sel;
        rd_ptr <= '0;
      end else if (line_shift) begin
        pixel <= (rd_ok && back_rd[3:0] != 4'd0) ? 8'(back_rd) : 8'd0;
        if (rd_ok) rd_ptr <= rd_ptr + ADDR_BITS'(1);
      end
      if (state == IDLE && line_load && !swap) begin
        addr <= line_addr;
        tile_addr <= line_tile;
        z <= line_z;
        pal <= line_palette;
      end
      if (state == LATCH) begin
        row <= tile_data;
        k <= 3'd0;
      end
      if (state == WRITE) begin
        row <= row >> 4;
        k <= k + 3'd1;
      end
    end
  end
  // Merge writes the front bank, display clears the back bank: never the same RAM in one cycle.
  always_ff @(posedge clk) begin
    if (merge_we && !bank_sel) bank0[m_idx] <= entry;
    if (disp_we && bank_sel) bank0[r_idx] <= '0;
    if (merge_we && bank_sel) bank1[m_idx] <= entry;
    if (disp_we && !bank_sel) bank1[r_idx] <= '0;
  end
endmodule
